dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single TMS4464 DRAM controller (addr/write/ena/ack/busy/rd_data handshake) between NREQ independent requesters, e.g. a memory tester and the display/debug reader.
- Arbitrates round-robin and registers the winning request's address, direction and write nybble. It holds them stable for the whole DRAM transaction, because the controller samples addr during row and column phases.
- Returns the completion and the 8-bit read data to the granted requester.
- Sits between the requesters and the controller. Its mem_wr_data drives the top-level tri-state ram_dq assignment.

Parameters:
- NREQ, 2, number of requesters, 2..4.
- TIMEOUT, 1023, cycles allowed in ISSUE or WAIT before abort. Counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-port request; held until req_ready
- req_ready  out  NREQ  one-cycle grant/accept pulse
- req_write  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*16  per-port address
- req_wdata  in  NREQ*4  per-port write nybble
- rsp_valid  out  NREQ  one-cycle completion pulse
- rsp_data  out  8  read data, valid with rsp_valid on a read
- err  out  1  sticky timeout flag
- mem_addr  out  16  to controller addr
- mem_write  out  1  to controller write
- mem_ena  out  1  to controller ena
- mem_wr_data  out  4  nybble driven onto ram_dq while ram_we_ is low
- mem_ack  in  1  controller ack (level: set at acceptance, cleared one cycle after it re-enters IDLE)
- mem_busy  in  1  controller not IDLE (INIT, refresh, access)
- mem_rd_data  in  8  controller data latch

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock.
- Reset values: state IDLE; req_ready=0, rsp_valid=0, mem_ena=0, mem_write=0, mem_addr=0, mem_wr_data=0, rsp_data=0, err=0; RR pointer grants port 0 first.
- FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Grants only when some req_valid=1 AND mem_busy=0 AND mem_ack=0. The mem_ack=0 condition rejects the stale ack that is still high in the controller's first IDLE cycle.
  - Winner is the first valid port strictly after the last granted port, wrapping modulo NREQ.
  - In the grant cycle: pulse req_ready[g]; register addr/write/wdata into mem_*; store g; update the pointer to g; go to ISSUE.
  - Grant-to-mem_ena latency is 1 cycle.
- ISSUE:
  - mem_ena=1 and is held until mem_ack=1.
  - If the controller starts a refresh (mem_busy=1 without ack), keep mem_ena high; the request is accepted after the refresh.
  - On mem_ack=1: mem_ena=0 that same edge, go to WAIT.
- WAIT:
  - On mem_busy=0: capture mem_rd_data into rsp_data (reads only; writes leave rsp_data unchanged), go to DONE.
- DONE:
  - Pulse rsp_valid[g] for exactly one cycle, then go to IDLE.
  - The next grant is possible no earlier than the cycle after mem_ack clears.
- mem_addr, mem_write and mem_wr_data are stable from grant until DONE. They are never changed while mem_busy=1.
- Timeout:
  - The counter clears on entry to ISSUE and does not reset on entry to WAIT, so it counts cycles spent in ISSUE and WAIT combined.
  - On reaching TIMEOUT: err<=1 (sticky until reset), mem_ena<=0, go to DONE.
  - rsp_valid[g] still pulses so the requester cannot hang; rsp_data is unchanged.
- Simultaneous requests: exactly one grant per transaction. Continuous requests from all ports produce a strict rotation.
- A req_valid that drops before req_ready is ignored; no grant is made to it.
- Reset mid-transaction:
  - The arbiter returns to IDLE; the controller has no reset and may still be busy.
  - The IDLE gating on mem_busy/mem_ack prevents any issue until the controller is quiescent.
  - An in-flight response is never delivered.
- No combinational path exists from any input to any output.

Decomposition:
- Package dram_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE)
  - DRAM_AW=16, DRAM_DW=4, DRAM_RW=8 widths
  - a request struct {write, addr, wdata}
- Sub-module rr_arbiter:
  - NREQ-bit request vector in, one-hot grant plus index out.
  - Contains the last-grant pointer register, advanced on an update strobe.
  - Same clk/rst_n.

Test Plan:
- Hold mem_busy=1 for 200 cycles after reset with req_valid[0]=1 -> no req_ready and mem_ena=0 until the cycle after mem_busy=0 and mem_ack=0. Then req_ready[0] pulses once and mem_ena rises the next cycle.
- Port0 write, addr=0x1234, wdata=0x5 -> mem_addr=0x1234, mem_write=1, mem_wr_data=0x5, all stable until DONE. mem_ena drops on the ack edge; rsp_valid[0] pulses once after mem_busy falls.
- Both ports continuously valid, 6 transactions -> grant order 0,1,0,1,0,1; no back-to-back issue while mem_ack is still high.
- Port1 read, addr=0xFF00, model returns 0xA7 -> rsp_data=0xA7 together with the rsp_valid[1] pulse; rsp_valid[0] stays 0.
- Model raises mem_busy for a 10-cycle refresh while mem_ena=1 and withholds ack -> mem_ena stays high throughout; transaction completes after the refresh; err=0.
- Model never acks, TIMEOUT=1023 -> err=1 at cycle 1023 of ISSUE, mem_ena=0, one rsp_valid pulse. Assert rst_n low mid-WAIT -> all outputs return to reset values immediately and err clears.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared types and widths for the DRAM arbiter
package dram_arb_pkg;

   localparam int DRAM_AW = 16;
   localparam int DRAM_DW = 4;
   localparam int DRAM_RW = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic               write;
      logic [DRAM_AW-1:0] addr;
      logic [DRAM_DW-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/dram_arbiter_rr.sv
// rtl/dram_arbiter_rr.sv - round-robin selector with a last-grant pointer
module rr_arbiter #(
   parameter int NREQ = 2,
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            update,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            gnt_any
);

   logic [IW-1:0] last;

   // Walk from the lowest-priority slot (last itself) towards last+1 so the
   // nearest valid port after last is the one left standing.
   always_comb begin
      int k;
      k       = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int i = NREQ; i >= 1; i--) begin
         k = (int'(last) + i) % NREQ;
         if (req[k]) begin
            gnt     = '0;
            gnt[k]  = 1'b1;
            gnt_idx = IW'(k);
            gnt_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= IW'(NREQ - 1);
      end else if (update) begin
         last <= gnt_idx;
      end
   end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - shares one DRAM controller between NREQ requesters
module dram_arbiter
   import dram_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_write,
   input  logic [NREQ*16-1:0]   req_addr,
   input  logic [NREQ*4-1:0]    req_wdata,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [DRAM_RW-1:0]   rsp_data,
   output logic                 err,
   output logic [DRAM_AW-1:0]   mem_addr,
   output logic                 mem_write,
   output logic                 mem_ena,
   output logic [DRAM_DW-1:0]   mem_wr_data,
   input  logic                 mem_ack,
   input  logic                 mem_busy,
   input  logic [DRAM_RW-1:0]   mem_rd_data
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   arb_state_e      state;
   logic [IW-1:0]   cur;
   logic [TW-1:0]   tmo_cnt;
   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;
   logic            grant_now;
   logic            tmo_hit;
   mem_req_t        sel;

   // A high mem_ack in IDLE is the previous transaction's ack not yet cleared.
   assign grant_now = (state == IDLE) && gnt_any && !mem_busy && !mem_ack;
   assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));

   always_comb begin
      sel       = '0;
      sel.write = req_write[gnt_idx];
      sel.addr  = req_addr[int'(gnt_idx)*DRAM_AW +: DRAM_AW];
      sel.wdata = req_wdata[int'(gnt_idx)*DRAM_DW +: DRAM_DW];
   end

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .update  (grant_now),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         req_ready   <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         err         <= 1'b0;
         mem_addr    <= '0;
         mem_write   <= 1'b0;
         mem_ena     <= 1'b0;
         mem_wr_data <= '0;
         cur         <= '0;
         tmo_cnt     <= '0;
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (grant_now) begin
                  req_ready   <= gnt;
                  mem_addr    <= sel.addr;
                  mem_write   <= sel.write;
                  mem_wr_data <= sel.wdata;
                  cur         <= gnt_idx;
                  tmo_cnt     <= '0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               // mem_ena stays up across a refresh; only the ack releases it.
               if (mem_ack) begin
                  mem_ena <= 1'b0;
                  tmo_cnt <= tmo_cnt + 1'b1;
                  state   <= WAIT;
               end else if (tmo_hit) begin
                  err            <= 1'b1;
                  mem_ena        <= 1'b0;
                  rsp_valid[cur] <= 1'b1;
                  state          <= DONE;
               end else begin
                  mem_ena <= 1'b1;
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WAIT: begin
               if (!mem_busy) begin
                  if (!mem_write) begin
                     rsp_data <= mem_rd_data;
                  end
                  rsp_valid[cur] <= 1'b1;
                  state          <= DONE;
               end else if (tmo_hit) begin
                  err            <= 1'b1;
                  rsp_valid[cur] <= 1'b1;
                  state          <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter with a controller model
module tb_dram_arbiter;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 1023;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   req_write;
   logic [NREQ*16-1:0] req_addr;
   logic [NREQ*4-1:0] req_wdata;
   logic [NREQ-1:0]   rsp_valid;
   logic [7:0]        rsp_data;
   logic              err;
   logic [15:0]       mem_addr;
   logic              mem_write;
   logic              mem_ena;
   logic [3:0]        mem_wr_data;
   logic              mem_ack;
   logic              mem_busy;
   logic [7:0]        mem_rd_data;

   int total = 0;
   int bad   = 0;

   // Controller model
   logic m_busy = 1'b0;
   logic m_ack  = 1'b0;
   int   m_cnt  = 0;
   logic ref_done = 1'b0;
   logic force_busy = 1'b1;
   logic no_ack = 1'b0;
   logic refresh_pend = 1'b0;
   int   acc_len = 4;
   logic [7:0] rd_val = 8'h00;

   assign mem_busy    = m_busy | force_busy;
   assign mem_ack     = m_ack;
   assign mem_rd_data = rd_val;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m_busy) begin
         if (m_cnt <= 1) m_busy <= 1'b0;
         else m_cnt <= m_cnt - 1;
      end else if (mem_ena && !m_ack && !force_busy && refresh_pend && !ref_done) begin
         m_busy   <= 1'b1;
         m_cnt    <= 10;
         ref_done <= 1'b1;
      end else if (mem_ena && !m_ack && !force_busy && !no_ack) begin
         m_busy <= 1'b1;
         m_ack  <= 1'b1;
         m_cnt  <= acc_len;
      end else if (m_ack) begin
         m_ack <= 1'b0;
      end
   end

   dram_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .err         (err),
      .mem_addr    (mem_addr),
      .mem_write   (mem_write),
      .mem_ena     (mem_ena),
      .mem_wr_data (mem_wr_data),
      .mem_ack     (mem_ack),
      .mem_busy    (mem_busy),
      .mem_rd_data (mem_rd_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_mem_ena"}, 32'(mem_ena), 32'd0);
      check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_wr_data"}, 32'(mem_wr_data), 32'd0);
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic wait_rsp(input string tag, input int p);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (rsp_valid != 0) got = 1'b1;
      end
      check({tag, "_rsp_seen"}, 32'(got), 32'd1);
      check({tag, "_rsp_port"}, 32'(rsp_valid), 32'(1 << p));
   endtask

   task automatic do_txn(input string tag, input int p, input bit wr, input logic [15:0] a,
                         input logic [3:0] wd, input logic [7:0] exp_d, input bit chk_ref);
      bit got;
      logic prev_busy, prev_ack;
      int stable_bad, ref_cyc, ena_bad, stray;
      @(negedge clk);
      req_write[p]          = wr;
      req_addr[p*16 +: 16]  = a;
      req_wdata[p*4 +: 4]   = wd;
      req_valid[p]          = 1'b1;
      got = 1'b0; stray = 0; prev_busy = 1'b1; prev_ack = 1'b1;
      for (int n = 0; n < 400 && !got; n++) begin
         prev_busy = mem_busy;
         prev_ack  = mem_ack;
         @(negedge clk);
         if (rsp_valid != 0) stray++;
         if (req_ready != 0) got = 1'b1;
      end
      req_valid[p] = 1'b0;
      check({tag, "_grant_seen"}, 32'(got), 32'd1);
      check({tag, "_grant_port"}, 32'(req_ready), 32'(1 << p));
      check({tag, "_idle_gate"}, 32'(prev_busy | prev_ack), 32'd0);
      check({tag, "_stray_rsp"}, 32'(stray), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
      check({tag, "_mem_write"}, 32'(mem_write), 32'(wr));
      check({tag, "_mem_wr_data"}, 32'(mem_wr_data), 32'(wd));
      got = 1'b0; stable_bad = 0; ref_cyc = 0; ena_bad = 0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (mem_addr !== a || mem_write !== wr || mem_wr_data !== wd) stable_bad++;
         if (mem_busy && !mem_ack) begin
            ref_cyc++;
            if (!mem_ena) ena_bad++;
         end
         if (rsp_valid != 0) got = 1'b1;
      end
      check({tag, "_rsp_seen"}, 32'(got), 32'd1);
      check({tag, "_rsp_port"}, 32'(rsp_valid), 32'(1 << p));
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_d));
      check({tag, "_stable"}, 32'(stable_bad), 32'd0);
      check({tag, "_ena_low_done"}, 32'(mem_ena), 32'd0);
      if (chk_ref) begin
         check({tag, "_refresh_cycles"}, 32'(ref_cyc), 32'd10);
         check({tag, "_refresh_ena_held"}, 32'(ena_bad), 32'd0);
         check({tag, "_refresh_err"}, 32'(err), 32'd0);
      end
      @(negedge clk);
      check({tag, "_rsp_one_pulse"}, 32'(rsp_valid), 32'd0);
   endtask

   typedef struct {
      int          port;
      bit          wr;
      logic [15:0] addr;
      logic [3:0]  wd;
      logic [7:0]  rd;
      logic [7:0]  exp_d;
   } vec_t;

   vec_t vecs[5];

   initial begin
      bit got;
      int viol, n, ena_hi;
      logic prev_busy, prev_ack;

      vecs[0] = '{0, 1'b1, 16'h1234, 4'h5, 8'h11, 8'h00};
      vecs[1] = '{1, 1'b0, 16'hFF00, 4'h0, 8'hA7, 8'hA7};
      vecs[2] = '{0, 1'b0, 16'h0001, 4'h3, 8'h3C, 8'h3C};
      vecs[3] = '{1, 1'b1, 16'hBEEF, 4'hA, 8'h55, 8'h3C};
      vecs[4] = '{1, 1'b0, 16'h8000, 4'h9, 8'h5A, 8'h5A};

      rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Busy controller after reset: nothing may be granted until it is quiescent
      req_write[0] = 1'b1; req_addr[15:0] = 16'h1234; req_wdata[3:0] = 4'h5; req_valid[0] = 1'b1;
      viol = 0;
      repeat (200) begin
         @(negedge clk);
         if (req_ready != 0 || mem_ena) viol++;
      end
      check("busy_hold", 32'(viol), 32'd0);
      force_busy = 1'b0;
      @(negedge clk);
      check("busy_release_ready", 32'(req_ready), 32'd1);
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("busy_release_ena", 32'(mem_ena), 32'd1);
      check("busy_release_no_dup", 32'(req_ready), 32'd0);
      wait_rsp("busy_release", 0);

      for (int i = 0; i < 5; i++) begin
         rd_val = vecs[i].rd;
         do_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].wr, vecs[i].addr,
                vecs[i].wd, vecs[i].rd == vecs[i].exp_d ? vecs[i].rd : vecs[i].exp_d, 1'b0);
      end

      // Rotation with both ports continuously valid
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      req_write = '0; req_addr = {16'h0200, 16'h0100}; req_wdata = '0; req_valid = 2'b11;
      for (int t = 0; t < 6; t++) begin
         got = 1'b0; prev_busy = 1'b1; prev_ack = 1'b1;
         for (n = 0; n < 400 && !got; n++) begin
            prev_busy = mem_busy;
            prev_ack  = mem_ack;
            @(negedge clk);
            if (req_ready != 0) got = 1'b1;
         end
         check($sformatf("rot%0d_grant", t), 32'(req_ready), 32'(1 << (t % 2)));
         check($sformatf("rot%0d_gate", t), 32'(prev_busy | prev_ack), 32'd0);
         check($sformatf("rot%0d_addr", t), 32'(mem_addr), (t % 2) ? 32'h0200 : 32'h0100);
         wait_rsp($sformatf("rot%0d", t), t % 2);
      end
      @(negedge clk); req_valid = '0;
      repeat (8) @(negedge clk);

      // Refresh while mem_ena is up
      refresh_pend = 1'b1;
      rd_val = 8'h99;
      do_txn("refresh", 0, 1'b0, 16'h4321, 4'h0, 8'h99, 1'b1);

      // Controller never acks
      no_ack = 1'b1;
      rd_val = 8'h77;
      @(negedge clk);
      req_write[1] = 1'b0; req_addr[31:16] = 16'h0F0F; req_valid[1] = 1'b1;
      got = 1'b0;
      for (n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (req_ready != 0) got = 1'b1;
      end
      req_valid[1] = 1'b0;
      check("tmo_grant", 32'(req_ready), 32'd2);
      n = 0; ena_hi = 0;
      while (!err && n < 1100) begin
         @(negedge clk);
         n++;
         if (mem_ena) ena_hi++;
      end
      check("tmo_cycles", 32'(n), 32'(TIMEOUT));
      check("tmo_ena_cycles", 32'(ena_hi), 32'(TIMEOUT - 1));
      check("tmo_ena_low", 32'(mem_ena), 32'd0);
      check("tmo_rsp", 32'(rsp_valid), 32'd2);
      check("tmo_rsp_data", 32'(rsp_data), 32'h99);
      @(negedge clk);
      check("tmo_one_pulse", 32'(rsp_valid), 32'd0);
      check("tmo_err_sticky", 32'(err), 32'd1);

      // Reset in the middle of WAIT
      no_ack = 1'b0; acc_len = 40;
      @(negedge clk);
      req_write[0] = 1'b1; req_addr[15:0] = 16'hAAAA; req_wdata[3:0] = 4'hC; req_valid[0] = 1'b1;
      got = 1'b0;
      for (n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (req_ready != 0) got = 1'b1;
      end
      req_valid[0] = 1'b0;
      check("midwait_grant", 32'(got), 32'd1);
      got = 1'b0;
      for (n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (mem_ack) got = 1'b1;
      end
      check("midwait_ack", 32'(got), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midwait_rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      acc_len = 4;
      rd_val = 8'h42;
      do_txn("after_rst", 1, 1'b0, 16'h5555, 4'h0, 8'h42, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
